// File: rtl/alu_shift_pipe.sv
// -----------------------------------------------------------------------------
// alu_shift_pipe
//   Two-stage pipelined barrel shifter with valid/ready handshaking on both
//   sides. Stage 1 performs the coarse shift (0/8/16/24 bits, from
//   shamt[4:3]). Stage 2 performs the fine shift (0-7 bits, from shamt[2:0]).
//   SLL is built on the right-shift datapath: the operand is bit-reversed on
//   entry to stage 1, and the stage 2 result is bit-reversed back before it
//   is registered. Only the valid bits are reset. Data and tag registers
//   carry no reset.
//
// Ports
//   clk       : clock; all state changes on its rising edge
//   rst_n     : asynchronous active-low reset (clears both valid bits)
//   flush     : synchronous kill of every in-flight operation
//   in_valid  : upstream offers an operation
//   in_ready  : operation is accepted this cycle (combinational)
//   in_a      : operand to shift
//   in_shamt  : shift amount 0-31
//   in_op     : 00=SLL, 01=SRL, 11=SRA, 10=pass-through (reserved)
//   in_tag    : destination tag carried alongside the operation
//   out_valid : result available (stage 2 valid)
//   out_ready : downstream accepts the result
//   out_y     : shifted result (registered)
//   out_tag   : tag of the presented result (registered)
// -----------------------------------------------------------------------------
module alu_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [4:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Mirror the bit order of a word.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    // Right shift that fills the vacated upper bits with 'fill'.
    function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] x,
                                                  input logic [4:0]       amt,
                                                  input logic             fill);
        logic [WIDTH-1:0] fill_mask;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        return (x >> amt) | (fill ? fill_mask : {WIDTH{1'b0}});
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_data_r;
    logic [2:0]       s1_fine_r;
    logic             s1_fill_r;
    logic             s1_rev_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_data_r;
    logic [TAG_W-1:0] s2_tag_r;

    logic             s2_load_s;
    logic             in_ready_s;
    logic             s1_load_s;

    logic             rev_s;
    logic             fill_s;
    logic             pass_s;
    logic [4:0]       coarse_amt_s;
    logic [2:0]       fine_amt_s;
    logic [WIDTH-1:0] s1_operand_s;
    logic [WIDTH-1:0] s1_data_d_s;
    logic [WIDTH-1:0] s2_fine_s;
    logic [WIDTH-1:0] s2_data_d_s;

    // Handshake: stage 1 moves on whenever stage 2 is empty or draining.
    always_comb begin
        s2_load_s  = !s2_valid_r || out_ready;
        in_ready_s = !s1_valid_r || s2_load_s;
        s1_load_s  = in_valid && in_ready_s;
    end

    // Stage 1 decode and coarse shift. The pass-through op forces both shift amounts to zero.
    always_comb begin
        rev_s  = 1'b0;
        fill_s = 1'b0;
        pass_s = 1'b0;
        case (in_op)
            OP_SLL:  rev_s  = 1'b1;
            OP_SRL:  fill_s = 1'b0;
            OP_SRA:  fill_s = in_a[WIDTH-1];
            default: pass_s = 1'b1;
        endcase
        if (pass_s) begin
            coarse_amt_s = 5'd0;
            fine_amt_s   = 3'd0;
        end else begin
            coarse_amt_s = {in_shamt[4:3], 3'b000};
            fine_amt_s   = in_shamt[2:0];
        end
        if (rev_s) begin
            s1_operand_s = bit_reverse(in_a);
        end else begin
            s1_operand_s = in_a;
        end
        s1_data_d_s = shr_fill(s1_operand_s, coarse_amt_s, fill_s);
    end

    // Stage 2 fine shift using the fill bit registered in stage 1, then undo the SLL reversal.
    always_comb begin
        s2_fine_s = shr_fill(s1_data_r, {2'b00, s1_fine_r}, s1_fill_r);
        if (s1_rev_r) begin
            s2_data_d_s = bit_reverse(s2_fine_s);
        end else begin
            s2_data_d_s = s2_fine_s;
        end
    end

    // Valid bits: asynchronous reset; flush beats any same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end
            if (s2_load_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Datapath and tag registers; these load only on transfers and need no reset.
    always_ff @(posedge clk) begin
        if (s1_load_s) begin
            s1_data_r <= s1_data_d_s;
            s1_fine_r <= fine_amt_s;
            s1_fill_r <= fill_s;
            s1_rev_r  <= rev_s;
            s1_tag_r  <= in_tag;
        end
        if (s2_load_s && s1_valid_r) begin
            s2_data_r <= s2_data_d_s;
            s2_tag_r  <= s1_tag_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign out_y     = s2_data_r;
    assign out_tag   = s2_tag_r;

endmodule
